sdbuf_xfer_ctrl: RTL and testbench

SDBUF_XFER_CTRL -- requirements
Module: sdbuf_xfer_ctrl

---
 rtl/sdbuf_xfer_ctrl_if.sv | 39 +++
 rtl/sdbuf_xfer_ctrl.sv | 143 ++++++++++++++
 tb/tb_sdbuf_xfer_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdbuf_xfer_ctrl_if.sv
// Control, buffer-port and stream signals between sdbuf_xfer_ctrl (slave) and its environment (master).
// The master side owns start/params/abort, buffer read data and the stream inputs.
interface sdbuf_xfer_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  dir;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [ADDR_WIDTH:0]   xfer_cnt;
  logic                  buf_ren;
  logic                  buf_wen;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;

  modport slave (
    input  start, dir, base_addr, count, abort, buf_rdata, rx_valid, rx_data, tx_ready,
    output busy, done, aborted, xfer_cnt, buf_ren, buf_wen, buf_addr, buf_wdata,
           rx_ready, tx_valid, tx_data
  );

  modport master (
    output start, dir, base_addr, count, abort, buf_rdata, rx_valid, rx_data, tx_ready,
    input  busy, done, aborted, xfer_cnt, buf_ren, buf_wen, buf_addr, buf_wdata,
           rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/sdbuf_xfer_ctrl.sv
// Buffer <-> stream transfer controller: RX writes one word per cycle, TX fetch/wait/send takes >= 3 cycles per word.
// rx_ready follows !abort combinationally; TX holds tx_valid/tx_data until tx_ready; abort wins over any handshake.
module sdbuf_xfer_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  sdbuf_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_TX_FETCH,
    S_TX_WAIT,
    S_TX_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_tx_valid;
  logic                  r_buf_ren;
  logic [DATA_WIDTH-1:0] r_tx_data;

  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   w_cnt_inc;
  logic                  w_last;
  logic                  w_rx_fire;
  logic                  w_tx_fire;

  assign w_len     = (bus.count > MAX_LEN) ? MAX_LEN : bus.count;
  // Address wraps naturally by dropping the count MSB.
  assign w_addr    = r_base + r_cnt[ADDR_WIDTH-1:0];
  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_last    = (w_cnt_inc == r_len);
  assign w_rx_fire = (r_state == S_RX) && bus.rx_valid && !bus.abort;
  assign w_tx_fire = (r_state == S_TX_SEND) && bus.tx_ready && !bus.abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_buf_ren  <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_buf_ren  <= 1'b0;
      r_tx_valid <= 1'b0;
      // r_busy is high exactly in the four active states.
      if (r_busy && bus.abort) begin
        r_aborted <= 1'b1;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_state   <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_base    <= bus.base_addr;
              r_len     <= w_len;
              r_cnt     <= '0;
              r_aborted <= 1'b0;
              if (bus.count == '0) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else if (bus.dir) begin
                r_busy    <= 1'b1;
                r_buf_ren <= 1'b1;
                r_state   <= S_TX_FETCH;
              end else begin
                r_busy  <= 1'b1;
                r_state <= S_RX;
              end
            end
          end
          S_RX: begin
            if (w_rx_fire) begin
              r_cnt <= w_cnt_inc;
              if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
          S_TX_FETCH: r_state <= S_TX_WAIT;
          S_TX_WAIT: begin
            r_tx_data  <= bus.buf_rdata;
            r_tx_valid <= 1'b1;
            r_state    <= S_TX_SEND;
          end
          S_TX_SEND: begin
            if (w_tx_fire) begin
              r_cnt <= w_cnt_inc;
              if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_buf_ren <= 1'b1;
                r_state   <= S_TX_FETCH;
              end
            end else begin
              r_tx_valid <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.aborted   = r_aborted;
  assign bus.xfer_cnt  = r_cnt;
  assign bus.buf_ren   = r_buf_ren;
  assign bus.buf_wen   = w_rx_fire;
  assign bus.buf_addr  = w_addr;
  assign bus.buf_wdata = bus.rx_data;
  assign bus.rx_ready  = (r_state == S_RX) && !bus.abort;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;

endmodule

// File: tb/tb_sdbuf_xfer_ctrl.sv
// Bench for sdbuf_xfer_ctrl: table of transfers plus reset / start-while-busy sequences,
// buffer model and scoreboard queues checked from a negedge monitor.
module tb_sdbuf_xfer_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clock;
  logic reset_n;

  sdbuf_xfer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdbuf_xfer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          dir;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    int            stall;
    int            abort_cyc;
    int            exp_cnt;
    logic          exp_ab;
    int            exp_done;
    int            exp_ren;
    int            exp_wen;
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int errors = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_tx[$];
  logic             prev_stall = 1'b0;
  logic [DW-1:0]    prev_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Synchronous-read buffer model.
  always @(posedge clock) begin
    if (bus.buf_wen) mem[bus.buf_addr] = bus.buf_wdata;
    if (bus.buf_ren) bus.buf_rdata <= mem[bus.buf_addr];
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.buf_ren) ren_cnt++;
      if (bus.buf_wen) begin
        wen_cnt++;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected actual=%0h/%0h expected=none", bus.buf_addr, bus.buf_wdata);
        end else begin
          chk("wr_word", {bus.buf_addr, bus.buf_wdata}, exp_wr.pop_front());
        end
      end
      if (bus.buf_ren || bus.buf_wen) chk("ren_wen_excl", bus.buf_ren & bus.buf_wen, 0);
      if (bus.tx_valid && bus.tx_ready && !bus.abort) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%0h expected=none", bus.tx_data);
        end else begin
          chk("tx_word", bus.tx_data, exp_tx.pop_front());
        end
      end
      if (prev_stall) chk("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
      prev_stall = bus.tx_valid && !bus.tx_ready && !bus.abort;
      prev_data  = bus.tx_data;
    end
  end

  // Entered and left at posedge+1.
  task automatic run_vec(input int idx, input vec_t v);
    int sent, cyc, stall_cnt, ren0, wen0, nwords;
    bit got_done;
    logic [DW-1:0] pat;
    logic [AW-1:0] a;
    pat = 32'hA000_0000 + (idx << 16);
    nwords = (v.count > 9'd256) ? 256 : int'(v.count);
    for (int i = 0; i < v.exp_cnt; i++) begin
      a = v.base + AW'(i);
      if (v.dir) exp_tx.push_back(pat + DW'(i));
      else       exp_wr.push_back({a, pat + DW'(i)});
    end
    if (v.dir) for (int i = 0; i < nwords; i++) begin
      a = v.base + AW'(i);
      mem[a] = pat + DW'(i);
    end
    ren0 = ren_cnt; wen0 = wen_cnt;
    bus.start = 1'b1; bus.dir = v.dir; bus.base_addr = v.base; bus.count = v.count;
    @(posedge clock); #1;
    bus.start = 1'b0;
    sent = 0; cyc = 0; stall_cnt = 0; got_done = 0;
    while (!got_done && cyc < 2000) begin
      bus.rx_valid = !v.dir;
      bus.rx_data  = pat + DW'(sent);
      bus.tx_ready = (stall_cnt >= v.stall);
      bus.abort    = (cyc == v.abort_cyc);
      @(negedge clock);
      if (bus.done) begin
        got_done = 1;
      end else begin
        if (bus.rx_valid && bus.rx_ready) sent++;
        if (bus.tx_valid && bus.tx_ready && !bus.abort) begin
          sent++; stall_cnt = 0;
        end else if (bus.tx_valid) begin
          stall_cnt++;
        end
        @(posedge clock); #1;
        cyc++;
      end
    end
    bus.abort = 1'b0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), got_done, 1);
    chk($sformatf("v%0d_done_cycle", idx), cyc, v.exp_done);
    chk($sformatf("v%0d_xfer_cnt", idx), bus.xfer_cnt, v.exp_cnt);
    chk($sformatf("v%0d_aborted", idx), bus.aborted, v.exp_ab);
    chk($sformatf("v%0d_busy_at_done", idx), bus.busy, 0);
    chk($sformatf("v%0d_ren_count", idx), ren_cnt - ren0, v.exp_ren);
    chk($sformatf("v%0d_wen_count", idx), wen_cnt - wen0, v.exp_wen);
    chk($sformatf("v%0d_queues_empty", idx), exp_wr.size() + exp_tx.size(), 0);
    exp_wr.delete(); exp_tx.delete();
    @(posedge clock); #1;
    @(negedge clock);
    chk($sformatf("v%0d_done_one_cycle", idx), bus.done, 0);
    chk($sformatf("v%0d_cnt_hold", idx), {bus.xfer_cnt, bus.aborted}, {9'(v.exp_cnt), v.exp_ab});
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit got_done;
    //                dir   base    count   stall abort cnt ab    done ren wen
    vecs[0] = '{1'b0, 8'h10, 9'd4,   0, -1, 4,   1'b0, 4,   0, 4};
    vecs[1] = '{1'b1, 8'hFE, 9'd3,   0, -1, 3,   1'b0, 9,   3, 0};
    vecs[2] = '{1'b1, 8'h40, 9'd2,   5, -1, 2,   1'b0, 16,  2, 0};
    vecs[3] = '{1'b0, 8'h20, 9'd8,   0, 2,  2,   1'b1, 3,   0, 2};
    vecs[4] = '{1'b0, 8'h33, 9'd0,   0, -1, 0,   1'b0, 0,   0, 0};
    vecs[5] = '{1'b1, 8'h33, 9'd0,   0, -1, 0,   1'b0, 0,   0, 0};
    vecs[6] = '{1'b0, 8'hFD, 9'd5,   0, -1, 5,   1'b0, 5,   0, 5};
    vecs[7] = '{1'b1, 8'h80, 9'd4,   0, 5,  1,   1'b1, 6,   2, 0};
    vecs[8] = '{1'b0, 8'h05, 9'h1FF, 0, -1, 256, 1'b0, 256, 0, 256};
    vecs[9] = '{1'b0, 8'h60, 9'd2,   0, -1, 2,   1'b0, 2,   0, 2};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 + i;
    reset_n = 1'b0;
    bus.start = 0; bus.dir = 0; bus.base_addr = '0; bus.count = '0; bus.abort = 0;
    bus.rx_valid = 0; bus.rx_data = '0; bus.tx_ready = 0; bus.buf_rdata = '0;
    #3;
    chk("reset_outputs",
        {bus.busy, bus.done, bus.aborted, bus.xfer_cnt, bus.tx_valid, bus.rx_ready,
         bus.buf_ren, bus.buf_wen, bus.buf_addr},
        0);
    chk("reset_tx_data", bus.tx_data, 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Start while busy must not disturb the latched parameters.
    for (int i = 0; i < 3; i++) exp_wr.push_back({8'h30 + 8'(i), 32'hB000_0000 + i});
    bus.start = 1; bus.dir = 0; bus.base_addr = 8'h30; bus.count = 9'd3;
    @(posedge clock); #1;
    bus.dir = 1; bus.base_addr = 8'h99; bus.count = 9'd7;
    @(negedge clock);
    chk("busy_ignore_start", {bus.busy, bus.buf_wen, bus.rx_ready}, 3'b101);
    @(posedge clock); #1;
    bus.start = 0;
    cyc = 0; got_done = 0;
    while (!got_done && cyc < 50) begin
      bus.rx_valid = 1; bus.rx_data = 32'hB000_0000 + 32'(3 - exp_wr.size());
      @(negedge clock);
      if (bus.done) got_done = 1;
      else begin @(posedge clock); #1; cyc++; end
    end
    bus.rx_valid = 0;
    chk("busy_start_done", {got_done, 6'(cyc)}, {1'b1, 6'd3});
    chk("busy_start_cnt", {bus.xfer_cnt, bus.aborted}, {9'd3, 1'b0});
    chk("busy_start_queue", exp_wr.size(), 0);
    exp_wr.delete();
    @(posedge clock); #1;

    // Asynchronous reset landing in TX_WAIT.
    bus.start = 1; bus.dir = 1; bus.base_addr = 8'h50; bus.count = 9'd2;
    @(posedge clock); #1;
    bus.start = 0; bus.tx_ready = 1;
    @(posedge clock); #1;
    chk("pre_reset_wait", {bus.busy, bus.buf_ren, bus.tx_valid}, 3'b100);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {bus.busy, bus.done, bus.aborted, bus.xfer_cnt, bus.tx_valid, bus.rx_ready,
         bus.buf_ren, bus.buf_wen, bus.buf_addr},
        0);
    chk("midreset_tx_data", bus.tx_data, 0);
    @(negedge clock); reset_n = 1'b1;
    bus.tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("no_done_after_reset", {bus.done, bus.busy, bus.tx_valid}, 0);
    end
    @(posedge clock); #1;
    run_vec(9, vecs[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
